// File: rtl/fifo_wr_packer.sv
// Splits one- or two-word payloads into single-word writes toward an async FIFO write port.
// Honors W_FULL backpressure; keeps a wrapping count of written words.
module fifo_wr_packer #(
  parameter int unsigned D_WIDTH   = 8,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                   W_CLK,
  input  logic                   W_RST,
  input  logic [2*D_WIDTH-1:0]   IN_DATA,
  input  logic                   IN_WIDE,
  input  logic                   IN_VALID,
  output logic                   IN_READY,
  input  logic                   W_FULL,
  output logic                   W_INC,
  output logic [D_WIDTH-1:0]     WR_DATA,
  output logic                   BUSY,
  output logic [CNT_WIDTH-1:0]   WORD_CNT
);

  localparam int unsigned P_WIDTH = 2 * D_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEND_LO = 2'd1,
    ST_SEND_HI = 2'd2
  } state_t;

  state_t                 state_q;
  logic [P_WIDTH-1:0]     data_q;
  logic                   wide_q;
  logic [CNT_WIDTH-1:0]   cnt_q;
  logic                   w_inc_c;

  // A word leaves only from a send state and only when the FIFO has room.
  assign w_inc_c = (state_q != ST_IDLE) && !W_FULL;

  always_ff @(posedge W_CLK or posedge W_RST) begin
    if (W_RST) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      wide_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      if (w_inc_c) begin
        cnt_q <= cnt_q + CNT_WIDTH'(1);
      end
      case (state_q)
        ST_IDLE: begin
          if (IN_VALID) begin
            data_q  <= IN_DATA;
            wide_q  <= IN_WIDE;
            state_q <= ST_SEND_LO;
          end
        end
        ST_SEND_LO: begin
          if (!W_FULL) begin
            state_q <= wide_q ? ST_SEND_HI : ST_IDLE;
          end
        end
        ST_SEND_HI: begin
          if (!W_FULL) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Write data is driven from the held payload only, so a stall keeps it stable.
  always_comb begin
    WR_DATA = '0;
    case (state_q)
      ST_SEND_LO: WR_DATA = data_q[D_WIDTH-1:0];
      ST_SEND_HI: WR_DATA = data_q[P_WIDTH-1:D_WIDTH];
      default:    WR_DATA = '0;
    endcase
  end

  assign W_INC    = w_inc_c;
  assign IN_READY = (state_q == ST_IDLE);
  assign BUSY     = (state_q != ST_IDLE);
  assign WORD_CNT = cnt_q;

endmodule

// File: doc/fifo_wr_packer.md
FIFO_WR_PACKER -- requirements
Module: fifo_wr_packer

Interface
REQ-001 SHALL have parameter D_WIDTH, default 8: FIFO data word width in bits.
REQ-002 SHALL have parameter CNT_WIDTH, default 16: width of the written-word counter.
REQ-003 SHALL have one clock; reset is asynchronous and active-high.
REQ-004 W_CLK  input  1  write-domain clock; all state updates on its rising edge.
REQ-005 W_RST  input  1  asynchronous active-high reset.
REQ-006 IN_DATA  input  2*D_WIDTH  payload; low word is [D_WIDTH-1:0], high word is [2*D_WIDTH-1:D_WIDTH].
REQ-007 IN_WIDE  input  1  1 = send two words (low then high); 0 = send low word only.
REQ-008 IN_VALID  input  1  payload offered this cycle.
REQ-009 IN_READY  output  1  packer accepts a payload this cycle.
REQ-010 W_FULL  input  1  full flag from the async FIFO write side; combinational from that side's registered pointers.
REQ-011 W_INC  output  1  FIFO write strobe; one word is written per cycle in which it is high.
REQ-012 WR_DATA  output  D_WIDTH  FIFO write data, qualified by W_INC.
REQ-013 BUSY  output  1  a captured payload still has unwritten words.
REQ-014 WORD_CNT  output  CNT_WIDTH  total words written since reset.

Function
REQ-015 SHALL implement a three-state FSM: IDLE, SEND_LO, SEND_HI.
REQ-016 IN_READY SHALL equal 1 exactly when the state is IDLE, decoded from registered state only.
REQ-017 Handshake: IN_VALID=1 and IN_READY=1 at an edge SHALL capture IN_DATA and IN_WIDE into holding registers and move the FSM to SEND_LO.
REQ-018 In IDLE with IN_VALID=0, the FSM SHALL stay in IDLE and W_INC SHALL be 0.
REQ-019 In SEND_LO: W_INC = ~W_FULL; WR_DATA = held low word.
REQ-020 In SEND_LO, if W_FULL=0 at the edge, the FSM SHALL go to SEND_HI when held IN_WIDE=1, otherwise to IDLE.
REQ-021 In SEND_HI: W_INC = ~W_FULL; WR_DATA = held high word; if W_FULL=0 at the edge, the FSM SHALL go to IDLE.
REQ-022 While W_FULL=1 in SEND_LO or SEND_HI, the FSM SHALL hold its state, and WR_DATA and held registers SHALL stay unchanged (backpressure stall, no word lost or duplicated).
REQ-023 W_INC SHALL never be 1 in a cycle where W_FULL=1.
REQ-024 W_INC SHALL never be 1 in IDLE.
REQ-025 W_INC and WR_DATA SHALL depend combinationally on only registered state, held data and W_FULL; there SHALL be no path from IN_VALID or IN_DATA to W_INC.
REQ-026 Latency: a payload captured at edge k SHALL produce its first W_INC in cycle k+1 if W_FULL=0.
REQ-027 The next IN_READY SHALL come one cycle after the last word is written.
REQ-028 Throughput SHALL be one narrow payload per 2 cycles and one wide payload per 3 cycles.
REQ-029 BUSY SHALL be 1 in SEND_LO and SEND_HI, and 0 in IDLE.
REQ-030 WORD_CNT SHALL increment by 1 at each edge where W_INC=1, and SHALL wrap modulo 2^CNT_WIDTH (all-ones -> 0) with no saturation or flag.
REQ-031 WR_DATA SHALL be 0 in IDLE.
REQ-032 W_FULL toggling mid-payload SHALL only stall; the word order SHALL always be low then high.

Reset
REQ-033 W_RST=1 SHALL immediately, without a clock, force: state IDLE, holding registers 0, WORD_CNT 0, W_INC 0, WR_DATA 0, BUSY 0, IN_READY 1.
REQ-034 Reset asserted mid-payload SHALL discard the unwritten words; after deassertion no stale write SHALL occur.
REQ-035 The first capture after reset SHALL be possible at the first rising edge after W_RST deasserts.

Verification
REQ-036 Narrow write, W_FULL=0: IN_DATA=16'hA55A, IN_WIDE=0, IN_VALID pulse -> next cycle W_INC=1, WR_DATA=8'h5A; then IDLE; WORD_CNT=1.
REQ-037 Wide write, W_FULL=0: IN_DATA=16'h1234, IN_WIDE=1 -> two consecutive cycles W_INC=1 with WR_DATA=8'h34 then 8'h12; IN_READY=0 for 2 cycles; WORD_CNT=2.
REQ-038 Backpressure: wide 16'hBEEF with W_FULL=1 held 3 cycles, then 0 -> W_INC=0 for 3 cycles with WR_DATA=8'hEF stable; then writes EF, BE; no duplicates.
REQ-039 Full between halves: W_FULL rises right after the low word is written -> SEND_HI holds 8'hBE with W_INC=0 until W_FULL=0, then a single write of BE.
REQ-040 Reset mid-payload: assert W_RST during SEND_HI -> W_INC=0, BUSY=0, WORD_CNT=0 at once; after release no write occurs until a new IN_VALID.
REQ-041 Counter wrap: CNT_WIDTH=4, 16 narrow writes -> WORD_CNT sequence ends 15 -> 0; random IN_VALID/W_FULL soak, scoreboard -> FIFO word stream equals input words in order.
